mmu_par_ctrl: RTL and testbench

Sequencer and access controller for the MMU page-address-register file (`memmap`). After reset it loads all 16 PARs (8 kernel, 8 user) with an identity map that matches unmapped behaviour. It then serves CPU register-window reads and writes through a four-phase handshake and drives memmap's `regwr`/`regrd`/`vaddr`. It also owns the MMU control register (MMCR), which gates memmap's `enable_i`.

---
 rtl/mmu_par_ctrl.sv | 145 ++++++++++++++
 tb/tb_mmu_par_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_par_ctrl.sv
// MMU PAR-file sequencer: optional identity-map init (MMU_PAR_INIT_EN), CPU register
// window with a four-phase handshake, and the MMCR translation-enable bit.
module mmu_par_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        cpu_sel,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic [15:0] cpu_vaddr,
  input  logic [15:0] mm_rdata,
  output logic        mm_regwr,
  output logic        mm_regrd,
  output logic [15:0] mm_vaddr,
  output logic [15:0] mm_wdata,
  output logic        mm_enable,
  output logic        init_done,
  output logic        xlat_stall
);

`ifdef MMU_PAR_INIT_EN
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD, S_RDC, S_ACK, S_REL} state_t;
  localparam state_t RESET_STATE = S_INIT;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDC, S_ACK, S_REL} state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_mmcr_en;
  logic        w_init_done;
  logic        w_accept;
  logic        w_is_par;
  logic        w_is_mmcr;

`ifdef MMU_PAR_INIT_EN
  logic [3:0]  r_n;
  logic        r_init_done;
  assign w_init_done = r_init_done;
`else
  assign w_init_done = 1'b1;
`endif

  assign w_accept  = (r_state == S_IDLE) && cpu_sel;
  assign w_is_par  = ~cpu_addr[4];
  assign w_is_mmcr = (cpu_addr == 5'd16);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= RESET_STATE;
    else if (ce)
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef MMU_PAR_INIT_EN
      S_INIT: if (r_n == 4'd15) w_next = S_IDLE;
`endif
      S_IDLE: begin
        if (cpu_sel) begin
          if (w_is_par) w_next = cpu_we ? S_WR : S_RD;
          else          w_next = S_ACK;
        end
      end
      S_WR:   w_next = S_ACK;
      S_RD:   w_next = S_RDC;
      S_RDC:  w_next = S_ACK;
      S_ACK:  w_next = S_REL;
      S_REL:  if (!cpu_sel) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_mmcr_en <= 1'b0;
`ifdef MMU_PAR_INIT_EN
      r_n         <= '0;
      r_init_done <= 1'b0;
`endif
    end else if (ce) begin
`ifdef MMU_PAR_INIT_EN
      if (r_state == S_INIT) begin
        r_n <= r_n + 4'd1;
        if (r_n == 4'd15) r_init_done <= 1'b1;
      end
`endif
      if (w_accept) begin
        r_addr  <= cpu_addr[3:0];
        r_wdata <= cpu_wdata;
        // MMCR and reserved accesses complete here; only their read data is produced now
        if (w_is_mmcr) begin
          if (cpu_we) r_mmcr_en <= cpu_wdata[0];
          else        r_rdata   <= {w_init_done, 14'b0, r_mmcr_en};
        end else if (!w_is_par && !cpu_we) begin
          r_rdata <= '0;
        end
      end
      if (r_state == S_RDC) r_rdata <= mm_rdata;
    end
  end

  always_comb begin
    mm_regwr   = 1'b0;
    mm_regrd   = 1'b0;
    mm_vaddr   = {11'b0, r_addr, 1'b0};
    mm_wdata   = r_wdata;
    cpu_ack    = 1'b0;
    xlat_stall = 1'b1;
    case (r_state)
`ifdef MMU_PAR_INIT_EN
      S_INIT: begin
        mm_regwr = 1'b1;
        mm_vaddr = {11'b0, r_n, 1'b0};
        mm_wdata = {~r_n[2], 5'b0, r_n[2:0], 7'b0};
      end
`endif
      S_IDLE, S_REL: begin
        mm_vaddr   = cpu_vaddr;
        xlat_stall = 1'b0;
      end
      S_WR:    mm_regwr = 1'b1;
      S_RD:    mm_regrd = 1'b1;
      S_ACK:   cpu_ack  = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rdata = r_rdata;
  assign init_done = w_init_done;
  assign mm_enable = r_mmcr_en & w_init_done;

endmodule

// File: tb/tb_mmu_par_ctrl.sv
// Bench for mmu_par_ctrl: memmap PAR array model, reference register model,
// directed and randomized register-window accesses with ce throttling.
module tb_mmu_par_ctrl;

  logic        clk = 1'b0;
  logic        reset, ce, cpu_sel, cpu_we;
  logic [4:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata, cpu_vaddr;
  logic        cpu_ack;
  logic [15:0] mm_rdata, mm_vaddr, mm_wdata;
  logic        mm_regwr, mm_regrd, mm_enable, init_done, xlat_stall;

  int total = 0;
  int bad   = 0;

`ifdef MMU_PAR_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  mmu_par_ctrl dut (
    .clk(clk), .reset(reset), .ce(ce),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_vaddr(cpu_vaddr), .mm_rdata(mm_rdata),
    .mm_regwr(mm_regwr), .mm_regrd(mm_regrd), .mm_vaddr(mm_vaddr),
    .mm_wdata(mm_wdata), .mm_enable(mm_enable),
    .init_done(init_done), .xlat_stall(xlat_stall)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  logic [31:0] wlog [$];
  int          rd_cnt = 0;
  bit          both_seen = 1'b0;

  always @(posedge clk) begin
    if (!reset && ce) begin
      if (mm_regwr) begin
        mem[mm_vaddr[4:1]] <= mm_wdata;
        wlog.push_back({mm_vaddr, mm_wdata});
      end
      if (mm_regrd) rd_cnt++;
    end
  end

  always @(negedge clk) if (mm_regwr === 1'b1 && mm_regrd === 1'b1) both_seen = 1'b1;

  assign mm_rdata = mem[mm_vaddr[4:1]];

  logic [15:0] ref_par [16];
  bit          ref_valid [16];
  bit          ref_mmcr;
  bit          ref_init;
  int          ce_div = 1;
  int          phase  = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step(output bit e);
    ce    = (phase == 0);
    phase = (phase + 1) % ce_div;
    e     = ce;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] init_word(input int k);
    int pg;
    pg = k % 8;
    return 16'((pg < 4 ? 32'h8000 : 0) + pg * 128);
  endfunction

  task automatic access(input bit we, input logic [4:0] addr, input logic [15:0] wd, input int hold);
    int nce, extra, wlen0, rd0, exp_lat, exp_w, exp_r;
    bit e, got, exp_en;
    logic [15:0] exp_rd;
    logic [31:0] exp_entry;
    wlen0   = wlog.size();
    rd0     = rd_cnt;
    exp_lat = (addr < 16) ? (we ? 1 : 2) : 0;
    if (addr < 16)       exp_rd = ref_par[addr[3:0]];
    else if (addr == 16) exp_rd = {ref_init, 14'b0, ref_mmcr};
    else                 exp_rd = 16'h0000;
    exp_w     = (we && addr < 16) ? 1 : 0;
    exp_r     = (!we && addr < 16) ? 1 : 0;
    exp_entry = {11'b0, addr[3:0], 1'b0, wd};

    cpu_sel = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    nce = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step(e);
      if (e) nce++;
      if (cpu_ack === 1'b1) got = 1'b1;
    end
    total++; if (got !== 1'b1) begin bad++; $error("FAIL ack_seen: got %0h want 1", got); end
    total++; if (nce !== exp_lat + 1) begin bad++; $error("FAIL latency: got %0d want %0d", nce, exp_lat + 1); end
    if (!we) begin
      total++; if (cpu_rdata !== exp_rd) begin bad++; $error("FAIL rdata: got %0h want %0h", cpu_rdata, exp_rd); end
    end

    if (we && addr < 16) begin ref_par[addr[3:0]] = wd; ref_valid[addr[3:0]] = 1'b1; end
    if (we && addr == 16) ref_mmcr = wd[0];

    e = 1'b0;
    for (int i = 0; i < 10 && !e; i++) step(e);
    total++; if (cpu_ack !== 1'b0) begin bad++; $error("FAIL ack_len: got %0h want 0", cpu_ack); end
    extra = 0;
    for (int i = 0; i < hold; i++) begin step(e); if (cpu_ack === 1'b1) extra++; end
    cpu_sel = 1'b0;
    for (int i = 0; i < 2 * ce_div + 1; i++) begin step(e); if (cpu_ack === 1'b1) extra++; end
    total++; if (extra !== 0) begin bad++; $error("FAIL no_repeat: got %0d want 0", extra); end
    total++; if (wlog.size() - wlen0 !== exp_w) begin bad++; $error("FAIL wr_count: got %0d want %0d", wlog.size() - wlen0, exp_w); end
    if (exp_w == 1) begin
      total++; if (wlog[wlen0] !== exp_entry) begin bad++; $error("FAIL wr_entry: got %0h want %0h", wlog[wlen0], exp_entry); end
    end
    total++; if (rd_cnt - rd0 !== exp_r) begin bad++; $error("FAIL rd_count: got %0d want %0d", rd_cnt - rd0, exp_r); end

    cpu_vaddr = 16'($urandom);
    #1;
    exp_en = ref_mmcr & ref_init;
    total++; if (mm_vaddr !== cpu_vaddr) begin bad++; $error("FAIL vaddr_pass: got %0h want %0h", mm_vaddr, cpu_vaddr); end
    total++; if (xlat_stall !== 1'b0) begin bad++; $error("FAIL stall_idle: got %0h want 0", xlat_stall); end
    total++; if (mm_enable !== exp_en) begin bad++; $error("FAIL enable: got %0h want %0h", mm_enable, exp_en); end
  endtask

  initial begin
    bit e;
    bit we;
    logic [4:0]  a;
    logic [15:0] w;
    logic [31:0] ent;
    logic [15:0] kv;
    logic [15:0] iw;
    int r;

    reset = 1'b1; ce = 1'b1; cpu_sel = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_vaddr = 16'h1234;
    for (int k = 0; k < 16; k++) begin ref_par[k] = '0; ref_valid[k] = 1'b0; end
    ref_mmcr = 1'b0;
    ref_init = ~INIT_EN;
    repeat (3) @(posedge clk);
    #1;

    total++; if (cpu_ack !== 1'b0) begin bad++; $error("FAIL rst_ack: got %0h want 0", cpu_ack); end
    total++; if (cpu_rdata !== 16'h0000) begin bad++; $error("FAIL rst_rdata: got %0h want 0", cpu_rdata); end
    total++; if (mm_enable !== 1'b0) begin bad++; $error("FAIL rst_enable: got %0h want 0", mm_enable); end
    total++; if (mm_regrd !== 1'b0) begin bad++; $error("FAIL rst_regrd: got %0h want 0", mm_regrd); end
    total++; if (mm_regwr !== INIT_EN) begin bad++; $error("FAIL rst_regwr: got %0h want %0h", mm_regwr, INIT_EN); end
    total++; if (init_done !== ~INIT_EN) begin bad++; $error("FAIL rst_init_done: got %0h want %0h", init_done, ~INIT_EN); end
    total++; if (xlat_stall !== INIT_EN) begin bad++; $error("FAIL rst_stall: got %0h want %0h", xlat_stall, INIT_EN); end
`ifdef MMU_PAR_INIT_EN
    total++; if (mm_vaddr !== 16'h0000) begin bad++; $error("FAIL rst_vaddr: got %0h want 0", mm_vaddr); end
    total++; if (mm_wdata !== 16'h8000) begin bad++; $error("FAIL rst_wdata: got %0h want 8000", mm_wdata); end
`endif

    wlog.delete();
    reset = 1'b0;
    ce_div = 1; phase = 0;
`ifdef MMU_PAR_INIT_EN
    for (int k = 0; k < 16; k++) begin
      total++; if (init_done !== 1'b0) begin bad++; $error("FAIL init_pending: got %0h want 0", init_done); end
      step(e);
    end
    total++; if (init_done !== 1'b1) begin bad++; $error("FAIL init_done: got %0h want 1", init_done); end
    total++; if (wlog.size() !== 16) begin bad++; $error("FAIL init_wcount: got %0d want 16", wlog.size()); end
    for (int k = 0; k < 16; k++) begin
      kv  = 16'(k * 2);
      iw  = init_word(k);
      ent = {kv, iw};
      total++; if (wlog[k] !== ent) begin bad++; $error("FAIL init_entry: got %0h want %0h", wlog[k], ent); end
      ref_par[k] = iw; ref_valid[k] = 1'b1;
    end
    ref_init = 1'b1;
`else
    repeat (4) step(e);
    total++; if (init_done !== 1'b1) begin bad++; $error("FAIL init_done: got %0h want 1", init_done); end
    total++; if (wlog.size() !== 0) begin bad++; $error("FAIL no_init_writes: got %0d want 0", wlog.size()); end
`endif
    total++; if (mm_vaddr !== cpu_vaddr) begin bad++; $error("FAIL idle_vaddr: got %0h want %0h", mm_vaddr, cpu_vaddr); end

    access(1'b1, 5'd9,  16'h8123, 0);
    access(1'b0, 5'd9,  16'h0000, 0);
    access(1'b1, 5'd16, 16'h0001, 0);
    access(1'b0, 5'd16, 16'h0000, 0);
    access(1'b1, 5'd16, 16'h0000, 0);
    access(1'b1, 5'd3,  16'h1111, 5);
    access(1'b0, 5'd3,  16'h0000, 5);
    access(1'b1, 5'd20, 16'hFFFF, 0);
    access(1'b1, 5'd16, 16'h0001, 0);
    access(1'b0, 5'd16, 16'h0000, 0);
    access(1'b0, 5'd25, 16'h0000, 0);
    access(1'b0, 5'd31, 16'h0000, 0);

    ce_div = 3; phase = 0;
    access(1'b0, 5'd9,  16'h0000, 2);
    access(1'b1, 5'd5,  16'hA5C3, 0);
    access(1'b0, 5'd5,  16'h0000, 0);
    access(1'b1, 5'd16, 16'h0000, 0);
    ce_div = 1; phase = 0;

    for (int it = 0; it < 40; it++) begin
      ce_div = $urandom_range(1, 3); phase = 0;
      r = $urandom_range(0, 9);
      if (r < 6)      a = 5'($urandom_range(0, 15));
      else if (r < 8) a = 5'd16;
      else            a = 5'($urandom_range(17, 31));
      we = 1'($urandom_range(0, 1));
      if (!we && a < 16 && !ref_valid[a[3:0]]) we = 1'b1;
      w = 16'($urandom);
      access(we, a, w, $urandom_range(0, 5));
    end
    ce_div = 1; phase = 0;

    access(1'b1, 5'd16, 16'h0001, 0);
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
    step(e);
    total++; if (mm_regrd !== 1'b1) begin bad++; $error("FAIL in_rd: got %0h want 1", mm_regrd); end
    reset = 1'b1;
    #1;
    ref_mmcr = 1'b0;
    ref_init = ~INIT_EN;
    total++; if (cpu_ack !== 1'b0) begin bad++; $error("FAIL mid_ack: got %0h want 0", cpu_ack); end
    total++; if (mm_enable !== 1'b0) begin bad++; $error("FAIL mid_enable: got %0h want 0", mm_enable); end
    total++; if (mm_regrd !== 1'b0) begin bad++; $error("FAIL mid_regrd: got %0h want 0", mm_regrd); end
    total++; if (mm_regwr !== INIT_EN) begin bad++; $error("FAIL mid_regwr: got %0h want %0h", mm_regwr, INIT_EN); end
    total++; if (init_done !== ~INIT_EN) begin bad++; $error("FAIL mid_init_done: got %0h want %0h", init_done, ~INIT_EN); end
    repeat (2) begin
      step(e);
      total++; if (cpu_ack !== 1'b0) begin bad++; $error("FAIL mid_ack_hold: got %0h want 0", cpu_ack); end
    end
    cpu_sel = 1'b0;
    wlog.delete();
    reset = 1'b0;
`ifdef MMU_PAR_INIT_EN
    total++; if (mm_vaddr !== 16'h0000) begin bad++; $error("FAIL reinit_vaddr: got %0h want 0", mm_vaddr); end
    repeat (16) step(e);
    total++; if (wlog.size() !== 16) begin bad++; $error("FAIL reinit_wcount: got %0d want 16", wlog.size()); end
    ent = {16'h0000, 16'h8000};
    total++; if (wlog[0] !== ent) begin bad++; $error("FAIL reinit_first: got %0h want %0h", wlog[0], ent); end
    total++; if (init_done !== 1'b1) begin bad++; $error("FAIL reinit_done: got %0h want 1", init_done); end
    for (int k = 0; k < 16; k++) ref_par[k] = init_word(k);
    ref_init = 1'b1;
`else
    repeat (2) step(e);
    total++; if (mm_enable !== 1'b0) begin bad++; $error("FAIL post_rst_enable: got %0h want 0", mm_enable); end
`endif
    access(1'b0, 5'd9,  16'h0000, 0);
    access(1'b0, 5'd16, 16'h0000, 0);

    total++; if (both_seen !== 1'b0) begin bad++; $error("FAIL exclusive_rw: got %0h want 0", both_seen); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
